uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit serializer placed directly downstream of the transmit buffer `buffer_t`. When the buffer reports data, it pops one byte, then shifts that byte out on the serial line as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, then stop bit(s). It paces every bit with an internal baud counter and reports busy and frame-done status back to the control logic.

## Interface
- `CLKS_PER_BIT`, default 868: `tClk` cycles per serial bit. Legal range is ≥ 2.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when parity is compiled in.
- `tClk`, input, 1: the single clock. All logic is on the rising edge.
- `tRst`, input, 1: reset. Asynchronous, active-low.
- `tEMPTY`, input, 1: buffer empty flag from `buffer_t`.
- `tdataIn`, input, 8: byte from buffer `tdataOut`. Valid one cycle after `tRD`.
- `tRD`, output, 1: pop request to the buffer. A one-cycle pulse.
- `txd`, output, 1: serial line. Idles high.
- `tbusy`, output, 1: high in every state except IDLE.
- `tdone`, output, 1: one-cycle pulse after the last stop bit.

## Operation
- States: IDLE, REQ, WAIT, START, DATA, PARITY (only when parity is compiled in), STOP. All outputs decode from registered state or registered flops.
- IDLE, with `txd`=1: if `tEMPTY`=0 at a rising edge, go to REQ. Otherwise stay in IDLE.
- REQ: `tRD`=1 for exactly this cycle, then go to WAIT.
- WAIT: capture `tdataIn` into the shift register at the end of the cycle, then go to START. `tEMPTY` is ignored here, because the byte has already been popped.
- START: `txd`=0 for `CLKS_PER_BIT` cycles.
- DATA: `txd`=shift[0]. Shift right every `CLKS_PER_BIT` cycles. A 3-bit index counts 0..7, and the state exits after index 7 completes.
- PARITY: `txd` = ^byte for even parity, or ~^byte for odd parity, held for one bit time.
- STOP: `txd`=1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then go to IDLE.
- `tdone` is high during the first IDLE cycle after STOP.
- Baud counter: width is $clog2(`CLKS_PER_BIT`). It counts 0..`CLKS_PER_BIT`-1, reloads to 0 on every state entry, and wraps with no residue.
- `tRD` is never asserted outside REQ. At most one pop occurs per frame.
- Reset values: state=IDLE, `txd`=1, `tRD`=0, `tbusy`=0, `tdone`=0, counters=0, shift register=0.
- Reset mid-frame: `txd` returns high immediately (asynchronously). The popped byte is discarded and not retransmitted.
- `tEMPTY` toggling during a frame has no effect. It is sampled only in IDLE.

## Timing
- Latency from `tEMPTY` falling (sampled at edge E0) to `tRD` high: `tRD` is high in the cycle after E0.
- The start bit begins 2 cycles after `tRD` rises.
- Frame length is (1+8+P+`STOP_BITS`)×`CLKS_PER_BIT` cycles, where P is 1 if parity is compiled in and 0 otherwise.
- Back-to-back frames:
  - The earliest next `tRD` is in the cycle after `tdone`.
  - The minimum high gap between the last stop bit and the next start bit is 3 cycles: IDLE, REQ, WAIT.
- `tbusy` rises in the cycle `tRD` is high. It falls at the same edge that sets `tdone`.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state exists, and one parity bit is inserted after D7, selected by `PARITY_ODD`.
  - Undefined: there is no PARITY state or logic, DATA goes directly to STOP, and `PARITY_ODD` is ignored.

## Test plan
- Reset then idle:
  - Stimulus: `tRst`=0 for 2 cycles, then release, with `tEMPTY`=1 for 50 cycles.
  - Required: `txd`=1, `tRD`=0, `tbusy`=0 throughout.
- Single byte:
  - Stimulus: `CLKS_PER_BIT`=4, no parity, `tdataIn`=8'hA5, `tEMPTY` low for one pop.
  - Required: exactly one `tRD` pulse, then `txd` = 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit; `tdone` pulses once, 40 cycles after the start bit begins.
- Parity:
  - Stimulus: `UART_TX_PARITY_EN` defined, `PARITY_ODD`=0, byte 8'hCC.
  - Required: parity bit 0, 11-bit frame.
  - Stimulus: `PARITY_ODD`=1, same byte.
  - Required: parity bit 1.
- Back-to-back:
  - Stimulus: `tEMPTY` held low, bytes 8'hCC then 8'h55.
  - Required: two `tRD` pulses, 3 idle-high cycles between frames, second frame correct.
- Mid-frame reset:
  - Stimulus: assert `tRst` during DATA bit 3.
  - Required: `txd`=1 immediately, no `tdone`. After release with `tEMPTY`=1, `txd` stays in IDLE.
- Two stop bits:
  - Stimulus: `STOP_BITS`=2, `CLKS_PER_BIT`=4.
  - Required: stop phase lasts 8 cycles, and `tdone` follows it.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Pops one byte from the upstream transmit buffer (buffer_t) whenever it
// reports data. The byte is then sent on txd as an asynchronous UART frame:
// a start bit, 8 data bits LSB first, an optional parity bit, and then
// STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT cycles of tClk.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> one parity bit is sent after D7; PARITY_ODD selects the sense
//   undefined -> no parity state or logic; PARITY_ODD has no effect
//
// Parameters
//   CLKS_PER_BIT  tClk cycles per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports
//   tClk     in   clock, rising edge
//   tRst     in   asynchronous active-low reset
//   tEMPTY   in   buffer empty flag, sampled only in IDLE
//   tdataIn  in   [7:0] popped byte, valid in the cycle after tRD
//   tRD      out  one-cycle pop request to the buffer
//   txd      out  serial line, idles high
//   tbusy    out  high whenever the FSM is not in IDLE
//   tdone    out  one-cycle pulse in the first IDLE cycle after the stop bits
//
// States
//   state  | meaning
//   IDLE   | line high, waiting for tEMPTY low
//   REQ    | tRD high for this single cycle
//   WAIT   | buffer drives tdataIn; byte captured at the end of the cycle
//   START  | start bit (txd low)
//   DATA   | data bits D0..D7, LSB first
//   PARITY | parity bit (only with UART_TX_PARITY_EN)
//   STOP   | STOP_BITS stop bits (txd high)
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       tClk,
    input  logic       tRst,
    input  logic       tEMPTY,
    input  logic [7:0] tdataIn,
    output logic       tRD,
    output logic       txd,
    output logic       tbusy,
    output logic       tdone
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    // Parameter values outside the legal range stop elaboration.
    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : gBadParams
        $error("uart_tx_serializer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    state_t        stateNext;
    logic [CW-1:0] baudCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          bitEnd;
    logic          bitTiming;
`ifdef UART_TX_PARITY_EN
    logic          parityBit;
`endif

    assign bitEnd = (baudCnt == BAUD_LAST);

    // State register
    always_ff @(posedge tClk or negedge tRst) begin
        if (!tRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic and output decode
    always_comb begin
        stateNext = state;
        bitTiming = 1'b0;
        txd       = 1'b1;
        case (state)
            IDLE: begin
                if (!tEMPTY) stateNext = REQ;
            end
            REQ: begin
                stateNext = WAIT;
            end
            WAIT: begin
                stateNext = START;
            end
            START: begin
                bitTiming = 1'b1;
                txd       = 1'b0;
                if (bitEnd) stateNext = DATA;
            end
            DATA: begin
                bitTiming = 1'b1;
                txd       = shiftReg[0];
                if (bitEnd && bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    stateNext = PARITY;
`else
                    stateNext = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                bitTiming = 1'b1;
                txd       = parityBit;
                if (bitEnd) stateNext = STOP;
            end
`endif
            STOP: begin
                bitTiming = 1'b1;
                if (bitEnd && bitIdx == STOP_LAST) stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign tRD   = (state == REQ);
    assign tbusy = (state != IDLE);

    // Baud/bit counters, shift register and done pulse. The baud counter is
    // cleared on every state change so each bit starts from a clean count.
    always_ff @(posedge tClk or negedge tRst) begin
        if (!tRst) begin
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            tdone    <= 1'b0;
        end else begin
            tdone <= (state == STOP) && (stateNext == IDLE);

            if (stateNext != state) begin
                baudCnt <= '0;
                bitIdx  <= '0;
            end else if (bitTiming) begin
                if (bitEnd) begin
                    baudCnt <= '0;
                    bitIdx  <= bitIdx + 3'd1;
                end else begin
                    baudCnt <= baudCnt + CW'(1);
                end
            end

            if (state == WAIT) begin
                shiftReg <= tdataIn;
            end else if (state == DATA && bitEnd) begin
                shiftReg <= {1'b0, shiftReg[7:1]};
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte as it is captured, because the shift
    // register has been emptied by the time the parity bit goes out.
    always_ff @(posedge tClk or negedge tRst) begin
        if (!tRst) begin
            parityBit <= 1'b0;
        end else if (state == WAIT) begin
            parityBit <= (PARITY_ODD != 0) ? ~^tdataIn : ^tdataIn;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Three serializers, all with CLKS_PER_BIT = 4, share the clock, the reset and
// tdataIn. Each has its own tEMPTY input:
//   dut 0 : STOP_BITS = 1, PARITY_ODD = 0
//   dut 1 : STOP_BITS = 2, PARITY_ODD = 0
//   dut 2 : STOP_BITS = 1, PARITY_ODD = 1
// Expected frames are written out by hand, one bit per element, with index 0
// being the start bit. Two sets are given, one for each UART_TX_PARITY_EN
// setting.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

    localparam int CPB = 4;

`ifdef UART_TX_PARITY_EN
    localparam int          NB     = 11;
    localparam logic [0:12] F_A5   = 13'b0101001010100;
    localparam logic [0:12] F_CC_E = 13'b0001100110100;
    localparam logic [0:12] F_CC_O = 13'b0001100111100;
    localparam logic [0:12] F_55   = 13'b0101010100100;
    localparam logic [0:12] F_3C_2 = 13'b0001111000110;
`else
    localparam int          NB     = 10;
    localparam logic [0:12] F_A5   = 13'b0101001011000;
    localparam logic [0:12] F_CC_E = 13'b0001100111000;
    localparam logic [0:12] F_CC_O = 13'b0001100111000;
    localparam logic [0:12] F_55   = 13'b0101010101000;
    localparam logic [0:12] F_3C_2 = 13'b0001111001100;
`endif

    logic       tClk = 1'b0;
    logic       tRst;
    logic [7:0] tdataIn;
    logic       tEmpty [3];
    logic       tRdV   [3];
    logic       txdV   [3];
    logic       busyV  [3];
    logic       doneV  [3];

    int compares = 0;
    int fails    = 0;
    int sel      = 0;

    always #5 tClk = ~tClk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .tClk(tClk), .tRst(tRst), .tEMPTY(tEmpty[0]), .tdataIn(tdataIn),
        .tRD(tRdV[0]), .txd(txdV[0]), .tbusy(busyV[0]), .tdone(doneV[0])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
        .tClk(tClk), .tRst(tRst), .tEMPTY(tEmpty[1]), .tdataIn(tdataIn),
        .tRD(tRdV[1]), .txd(txdV[1]), .tbusy(busyV[1]), .tdone(doneV[1])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut2 (
        .tClk(tClk), .tRst(tRst), .tEMPTY(tEmpty[2]), .tdataIn(tdataIn),
        .tRD(tRdV[2]), .txd(txdV[2]), .tbusy(busyV[2]), .tdone(doneV[2])
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (dut %0d) observed=%b expected=%b", tag, sel, obs, exp);
        end
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge tClk);
            chk({tag, "_txd"},   txdV[sel],  1'b1);
            chk({tag, "_trd"},   tRdV[sel],  1'b0);
            chk({tag, "_busy"},  busyV[sel], 1'b0);
            chk({tag, "_done"},  doneV[sel], 1'b0);
        end
    endtask

    // The caller has just set tEmpty[sel] low (or left it low) while the DUT
    // is in IDLE, so the next cycle is REQ. The task returns right after the
    // tdone cycle has been checked.
    task automatic runFrame(input logic [7:0] b, input logic [0:12] exp,
                            input int nbits, input bit keepLow, input bit toggle);
        tdataIn = b;
        @(negedge tClk);
        chk("req_trd",  tRdV[sel],  1'b1);
        chk("req_busy", busyV[sel], 1'b1);
        chk("req_txd",  txdV[sel],  1'b1);
        if (!keepLow) tEmpty[sel] = 1'b1;
        @(negedge tClk);
        chk("wait_trd",  tRdV[sel],  1'b0);
        chk("wait_txd",  txdV[sel],  1'b1);
        chk("wait_busy", busyV[sel], 1'b1);
        for (int i = 0; i < nbits * CPB; i++) begin
            if (toggle) tEmpty[sel] = (i % 3 == 0 && i < nbits * CPB - 2) ? 1'b0 : 1'b1;
            @(negedge tClk);
            chk("frame_txd",  txdV[sel],  exp[i / CPB]);
            chk("frame_trd",  tRdV[sel],  1'b0);
            chk("frame_busy", busyV[sel], 1'b1);
            chk("frame_done", doneV[sel], 1'b0);
        end
        @(negedge tClk);
        chk("done_pulse", doneV[sel], 1'b1);
        chk("done_busy",  busyV[sel], 1'b0);
        chk("done_txd",   txdV[sel],  1'b1);
        chk("done_trd",   tRdV[sel],  1'b0);
    endtask

    task automatic afterFrame();
        @(negedge tClk);
        chk("post_done", doneV[sel], 1'b0);
        chk("post_trd",  tRdV[sel],  1'b0);
        chk("post_busy", busyV[sel], 1'b0);
        chk("post_txd",  txdV[sel],  1'b1);
    endtask

    initial begin
        tRst      = 1'b0;
        tdataIn   = 8'h00;
        tEmpty[0] = 1'b1;
        tEmpty[1] = 1'b1;
        tEmpty[2] = 1'b1;

        // Reset, then idle with tEMPTY high
        sel = 0;
        repeat (2) @(negedge tClk);
        chk("rst_txd",  txdV[0],  1'b1);
        chk("rst_trd",  tRdV[0],  1'b0);
        chk("rst_busy", busyV[0], 1'b0);
        chk("rst_done", doneV[0], 1'b0);
        tRst = 1'b1;
        idleCycles(50, "idle");

        // Single byte A5
        tEmpty[0] = 1'b0;
        runFrame(8'hA5, F_A5, NB, 1'b0, 1'b0);
        afterFrame();
        idleCycles(3, "gap1");

        // Byte CC, even parity (PARITY_ODD is ignored when parity is not built in)
        tEmpty[0] = 1'b0;
        runFrame(8'hCC, F_CC_E, NB, 1'b0, 1'b0);
        afterFrame();

        // Byte CC, odd parity, with tEMPTY toggling during the frame
        sel = 2;
        idleCycles(2, "pre_odd");
        tEmpty[2] = 1'b0;
        runFrame(8'hCC, F_CC_O, NB, 1'b0, 1'b1);
        afterFrame();
        idleCycles(5, "post_odd");

        // Back-to-back CC then 55 with tEMPTY held low
        sel = 0;
        tEmpty[0] = 1'b0;
        runFrame(8'hCC, F_CC_E, NB, 1'b1, 1'b0);
        runFrame(8'h55, F_55, NB, 1'b0, 1'b0);
        afterFrame();
        idleCycles(3, "post_b2b");

        // Two stop bits
        sel = 1;
        tEmpty[1] = 1'b0;
        runFrame(8'h3C, F_3C_2, NB + 1, 1'b0, 1'b0);
        afterFrame();

        // Reset during data bit 3 of A5 (bit value 0)
        sel = 0;
        tdataIn   = 8'hA5;
        tEmpty[0] = 1'b0;
        @(negedge tClk);
        chk("mid_req_trd", tRdV[0], 1'b1);
        tEmpty[0] = 1'b1;
        @(negedge tClk);
        repeat (4 * CPB + 1) @(negedge tClk);
        chk("mid_pre_txd",  txdV[0],  1'b0);
        chk("mid_pre_busy", busyV[0], 1'b1);
        #2;
        tRst = 1'b0;
        #1;
        chk("mid_rst_txd",  txdV[0],  1'b1);
        chk("mid_rst_busy", busyV[0], 1'b0);
        chk("mid_rst_trd",  tRdV[0],  1'b0);
        chk("mid_rst_done", doneV[0], 1'b0);
        repeat (2) begin
            @(negedge tClk);
            chk("mid_hold_done", doneV[0], 1'b0);
            chk("mid_hold_txd",  txdV[0],  1'b1);
        end
        tRst = 1'b1;
        idleCycles(20, "mid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
